// File: rtl/fifo_tx_framer.sv
// -----------------------------------------------------------------------------
// fifo_tx_framer
//   Transmit-side packet framer feeding the write port of an async FIFO.
//   Each packet leaves as: SOF, sequence number, payload bytes, XOR checksum.
//   The checksum covers the sequence byte and every payload byte. Payloads
//   longer than MAX_LEN are force-closed, and the remaining source bytes start
//   a fresh packet.
//
// Ports
//   trans_clk     in   clock
//   trans_rst     in   asynchronous active-low reset
//   src_data      in   payload byte from source
//   src_valid     in   src_data valid
//   src_last      in   final payload byte of the packet
//   src_ready     out  framer accepts src_data this cycle
//   fifo_full     in   FIFO full flag; while it is high the framer holds and never writes
//   write_enable  out  FIFO write strobe
//   trans_data    out  FIFO write data (zero when write_enable is low)
//   busy          out  packet in progress
//   pkt_count     out  packets completed since reset (wraps)
//   len_err       out  pulse on the transfer cycle that force-closes a packet
// -----------------------------------------------------------------------------
module fifo_tx_framer #(
    parameter int                DATA_W  = 8,
    parameter int                MAX_LEN = 16,
    parameter logic [DATA_W-1:0] SOF     = 8'hA5
) (
    input  logic              trans_clk,
    input  logic              trans_rst,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    input  logic              src_last,
    output logic              src_ready,
    input  logic              fifo_full,
    output logic              write_enable,
    output logic [DATA_W-1:0] trans_data,
    output logic              busy,
    output logic [15:0]       pkt_count,
    output logic              len_err
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEQ, PAY, CSUM} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] seq_reg;
    logic [DATA_W-1:0] csum_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [15:0]       pkt_count_reg;

    // The FIFO samples these on the same edge that advances the state, so
    // they are decoded combinationally. Gating with trans_rst keeps every
    // strobe low while reset is held, even if src_valid is high in IDLE.
    always_comb begin
        write_enable = 1'b0;
        src_ready    = 1'b0;
        trans_data   = '0;
        len_err      = 1'b0;
        if (trans_rst && !fifo_full) begin
            case (state_reg)
                IDLE: begin
                    if (src_valid) begin
                        write_enable = 1'b1;
                        trans_data   = SOF;
                    end
                end
                SEQ: begin
                    write_enable = 1'b1;
                    trans_data   = seq_reg;
                end
                PAY: begin
                    src_ready = 1'b1;
                    if (src_valid) begin
                        write_enable = 1'b1;
                        trans_data   = src_data;
                        // Length close without a last flag: the source overran MAX_LEN.
                        len_err      = (len_reg == LEN_LAST) && !src_last;
                    end
                end
                CSUM: begin
                    write_enable = 1'b1;
                    trans_data   = csum_reg;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign pkt_count = pkt_count_reg;

    // Every state holds while fifo_full is high, so a stall resumes exactly
    // on the byte that was blocked.
    always_ff @(posedge trans_clk or negedge trans_rst) begin
        if (!trans_rst) begin
            state_reg     <= IDLE;
            seq_reg       <= '0;
            csum_reg      <= '0;
            len_reg       <= '0;
            pkt_count_reg <= '0;
        end else if (!fifo_full) begin
            case (state_reg)
                IDLE: begin
                    // src_valid only triggers the header; the byte is taken in PAY.
                    if (src_valid) begin
                        csum_reg  <= '0;
                        len_reg   <= '0;
                        state_reg <= SEQ;
                    end
                end
                SEQ: begin
                    csum_reg  <= seq_reg;
                    state_reg <= PAY;
                end
                PAY: begin
                    if (src_valid) begin
                        csum_reg <= csum_reg ^ src_data;
                        len_reg  <= len_reg + 1'b1;
                        if (src_last || (len_reg == LEN_LAST)) begin
                            state_reg <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    seq_reg       <= seq_reg + 1'b1;
                    pkt_count_reg <= pkt_count_reg + 16'd1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx_framer.sv
module tb_fifo_tx_framer;

    logic        trans_clk = 1'b0;
    logic        trans_rst = 1'b0;
    logic [7:0]  src_data  = 8'h00;
    logic        src_valid = 1'b0;
    logic        src_last  = 1'b0;
    logic        src_ready;
    logic        fifo_full = 1'b0;
    logic        write_enable;
    logic [7:0]  trans_data;
    logic        busy;
    logic [15:0] pkt_count;
    logic        len_err;

    fifo_tx_framer #(.DATA_W(8), .MAX_LEN(16), .SOF(8'hA5)) dut (
        .trans_clk    (trans_clk),
        .trans_rst    (trans_rst),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .fifo_full    (fifo_full),
        .write_enable (write_enable),
        .trans_data   (trans_data),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .len_err      (len_err)
    );

    always #5 trans_clk = ~trans_clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_seq = 8'h00;
    int         len_err_cnt = 0;
    logic [7:0] len_err_data = 8'h00;
    bit         gap_en = 1'b0;
    int         gap_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    // Scoreboard: every FIFO write is popped against the expected queue.
    always @(negedge trans_clk) begin
        logic [7:0] e;
        if (trans_rst) begin
            if (write_enable) begin
                check("write_while_full", {31'd0, fifo_full}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write got %02h required no write", trans_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("write %02h expected %02h", trans_data, e);
                    check("write_data", {24'd0, trans_data}, {24'd0, e});
                end
                if (len_err) begin
                    len_err_cnt++;
                    len_err_data = trans_data;
                end
            end else begin
                check("idle_data_zero", {24'd0, trans_data}, 32'd0);
                if (len_err) len_err_cnt++;
                if (gap_en && exp_q.size() != 0) gap_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last, input bit stall);
        int cnt;
        src_data  = d;
        src_valid = 1'b1;
        src_last  = last;
        if (stall) begin
            fifo_full = 1'b1;
            repeat (3) begin
                @(negedge trans_clk);
                check("stall_we", {31'd0, write_enable}, 32'd0);
                check("stall_ready", {31'd0, src_ready}, 32'd0);
            end
            @(posedge trans_clk);
            #1 fifo_full = 1'b0;
        end
        cnt = 0;
        forever begin
            @(negedge trans_clk);
            if (src_ready) break;
            cnt++;
            if (cnt > 50) begin
                n_vec++;
                n_bad++;
                $display("FAIL ready_timeout got 0 required 1");
                break;
            end
        end
        @(posedge trans_clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge trans_clk);
        check("drain_queue_empty", exp_q.size(), 32'd0);
        @(posedge trans_clk);
        @(negedge trans_clk);
    endtask

    task automatic do_reset();
        @(posedge trans_clk);
        #1;
        trans_rst = 1'b0;
        src_valid = 1'b1;
        fifo_full = 1'b0;
        @(negedge trans_clk);
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_ready", {31'd0, src_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, trans_data}, 32'd0);
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_len_err", {31'd0, len_err}, 32'd0);
        src_valid = 1'b0;
        @(posedge trans_clk);
        #1 trans_rst = 1'b1;
        exp_seq = 8'h00;
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]  data [4];
        int          n;
        int          stall_at;
        logic [7:0]  exp_csum;
        logic [15:0] exp_pkt;
    } vec_t;

    vec_t tbl [4];

    initial begin
        // Hand-computed checksums: csum = seq ^ payload bytes.
        tbl[0].data = '{8'h01, 8'h02, 8'h04, 8'h00}; tbl[0].n = 3; tbl[0].stall_at = -1;
        tbl[0].exp_csum = 8'h07; tbl[0].exp_pkt = 16'd1;
        tbl[1].data = '{8'h01, 8'h02, 8'h04, 8'h00}; tbl[1].n = 3; tbl[1].stall_at = 1;
        tbl[1].exp_csum = 8'h06; tbl[1].exp_pkt = 16'd2;
        tbl[2].data = '{8'hFF, 8'h00, 8'h00, 8'h00}; tbl[2].n = 1; tbl[2].stall_at = -1;
        tbl[2].exp_csum = 8'hFD; tbl[2].exp_pkt = 16'd3;
        tbl[3].data = '{8'h10, 8'h20, 8'h30, 8'h40}; tbl[3].n = 4; tbl[3].stall_at = -1;
        tbl[3].exp_csum = 8'h43; tbl[3].exp_pkt = 16'd4;

        do_reset();

        // Table-driven packets.
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(exp_seq);
            for (int i = 0; i < tbl[v].n; i++) exp_q.push_back(tbl[v].data[i]);
            exp_q.push_back(tbl[v].exp_csum);
            gap_cnt = 0;
            gap_en  = (tbl[v].stall_at < 0);
            for (int i = 0; i < tbl[v].n; i++)
                send_byte(tbl[v].data[i], (i == tbl[v].n - 1), (i == tbl[v].stall_at));
            src_valid = 1'b0;
            src_last  = 1'b0;
            drain();
            gap_en = 1'b0;
            exp_seq++;
            check("vec_busy_after", {31'd0, busy}, 32'd0);
            check("vec_pkt_count", {16'd0, pkt_count}, {16'd0, tbl[v].exp_pkt});
            if (tbl[v].stall_at < 0) check("vec_no_gap", gap_cnt, 32'd0);
        end
        check("no_len_err_yet", len_err_cnt, 32'd0);

        // Overlong stream: forced close at 16 bytes, the rest becomes packet 2.
        do_reset();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        for (int i = 16; i < 20; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h01);
        for (int i = 0; i < 20; i++) send_byte(8'(i), (i == 19), 1'b0);
        src_valid = 1'b0;
        src_last  = 1'b0;
        drain();
        check("len_err_pulses", len_err_cnt, 32'd1);
        check("len_err_byte", {24'd0, len_err_data}, 32'h0F);
        check("overlong_pkt_count", {16'd0, pkt_count}, 32'd2);
        exp_seq = 8'h02;

        // Asynchronous reset mid-payload.
        exp_q.push_back(8'hA5);
        exp_q.push_back(exp_seq);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        src_data  = 8'hCC;
        src_valid = 1'b1;
        #1 trans_rst = 1'b0;
        #1;
        check("async_rst_we", {31'd0, write_enable}, 32'd0);
        check("async_rst_ready", {31'd0, src_ready}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_data", {24'd0, trans_data}, 32'd0);
        check("async_rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("async_rst_partial_written", exp_q.size(), 32'd0);
        src_valid = 1'b0;
        @(posedge trans_clk);
        @(posedge trans_clk);
        #1 trans_rst = 1'b1;
        exp_seq = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0);
        src_valid = 1'b0;
        src_last  = 1'b0;
        drain();
        check("post_rst_pkt_count", {16'd0, pkt_count}, 32'd1);

        // 257 back-to-back one-byte packets: sequence wraps, no idle cycles.
        do_reset();
        gap_cnt = 0;
        gap_en  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(exp_seq);
            exp_q.push_back(8'(i));
            exp_q.push_back(exp_seq ^ 8'(i));
            send_byte(8'(i), 1'b1, 1'b0);
            exp_seq++;
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
        drain();
        gap_en = 1'b0;
        check("b2b_pkt_count", {16'd0, pkt_count}, 32'd257);
        check("b2b_no_gap", gap_cnt, 32'd0);
        check("b2b_busy_after", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
